// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: condition-code encoding and NZCV flag bit positions.
package alu_defs;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_commit_stage_cond_check.sv
// Combinational condition-code evaluation of a 4-bit cond against NZCV flags.
module cond_check
  import alu_defs::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    cond_ex_o = 1'b1;
    case (cond_e'(cond_i))
      EQ: cond_ex_o = z;
      NE: cond_ex_o = !z;
      CS: cond_ex_o = c;
      CC: cond_ex_o = !c;
      MI: cond_ex_o = n;
      PL: cond_ex_o = !n;
      VS: cond_ex_o = v;
      VC: cond_ex_o = !v;
      HI: cond_ex_o = c & !z;
      LS: cond_ex_o = !c | z;
      GE: cond_ex_o = (n == v);
      LT: cond_ex_o = (n != v);
      GT: cond_ex_o = !z & (n == v);
      LE: cond_ex_o = z | (n != v);
      // AL and the unnamed 4'b1111 encoding both always execute.
      default: cond_ex_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_commit_stage.sv
// Post-ALU stage: NZCV register, condition gating of side effects, flag
// commit, and a 2-entry FIFO toward writeback with valid/ready on both sides.
module cond_commit_stage
  import alu_defs::*;
#(
  parameter int N      = 4,
  parameter int REG_AW = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [N-1:0]      result_i,
  input  logic [3:0]        alu_flags_i,
  input  logic [3:0]        cond_i,
  input  logic [1:0]        flag_w_i,
  input  logic              reg_write_i,
  input  logic              mem_write_i,
  input  logic              pc_src_i,
  input  logic [REG_AW-1:0] rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [N-1:0]      result_o,
  output logic              reg_write_o,
  output logic              mem_write_o,
  output logic              pc_src_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              cond_ex_o,
  output logic [3:0]        flags_o
);

  typedef struct packed {
    logic [N-1:0]      result;
    logic [REG_AW-1:0] rd;
    logic              cond_ex;
    logic              reg_write;
    logic              mem_write;
    logic              pc_src;
  } entry_t;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends combinationally on ready on either side.
  logic       accept, pop, cond_ex;
  logic [3:0] flags_d, flags_q;
  logic [1:0] count_d, count_q;
  logic       wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  entry_t     mem_d [2];
  entry_t     mem_q [2];
  entry_t     head;

  cond_check u_cond_check (
    .cond_i    (cond_i),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ex)
  );

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign accept      = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    flags_d = flags_q;
    if (accept && cond_ex) begin
      if (flag_w_i[FW_NZ]) begin
        flags_d[FLAG_N] = alu_flags_i[FLAG_N];
        flags_d[FLAG_Z] = alu_flags_i[FLAG_Z];
      end
      if (flag_w_i[FW_CV]) begin
        flags_d[FLAG_C] = alu_flags_i[FLAG_C];
        flags_d[FLAG_V] = alu_flags_i[FLAG_V];
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      mem_d[wr_ptr_q].result    = result_i;
      mem_d[wr_ptr_q].rd        = rd_i;
      mem_d[wr_ptr_q].cond_ex   = cond_ex;
      mem_d[wr_ptr_q].reg_write = reg_write_i & cond_ex;
      mem_d[wr_ptr_q].mem_write = mem_write_i & cond_ex;
      mem_d[wr_ptr_q].pc_src    = pc_src_i & cond_ex;
      wr_ptr_d                  = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q  <= '0;
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      flags_q  <= flags_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign result_o    = head.result;
  assign rd_o        = head.rd;
  assign cond_ex_o   = head.cond_ex;
  assign reg_write_o = head.reg_write;
  assign mem_write_o = head.mem_write;
  assign pc_src_o    = head.pc_src;
  assign flags_o     = flags_q;

endmodule

// File: tb/tb_cond_commit_stage.sv
// Scoreboard bench for cond_commit_stage: directed ops push expected head
// entries, a negedge monitor pops and compares on every writeback transfer.
module tb_cond_commit_stage;

  localparam int N = 4;
  localparam int REG_AW = 4;
  localparam int W = N + REG_AW + 4;

  logic              clk_i, rst_ni;
  logic              in_valid_i, in_ready_o;
  logic [N-1:0]      result_i;
  logic [3:0]        alu_flags_i, cond_i;
  logic [1:0]        flag_w_i;
  logic              reg_write_i, mem_write_i, pc_src_i;
  logic [REG_AW-1:0] rd_i;
  logic              out_valid_o, out_ready_i;
  logic [N-1:0]      result_o;
  logic              reg_write_o, mem_write_o, pc_src_o, cond_ex_o;
  logic [REG_AW-1:0] rd_o;
  logic [3:0]        flags_o;

  logic [W-1:0] exp_q[$];
  logic [3:0]   tb_flags;
  int           n_vec, n_err;

  cond_commit_stage #(.N(N), .REG_AW(REG_AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .result_i(result_i), .alu_flags_i(alu_flags_i), .cond_i(cond_i),
    .flag_w_i(flag_w_i), .reg_write_i(reg_write_i), .mem_write_i(mem_write_i),
    .pc_src_i(pc_src_i), .rd_i(rd_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .reg_write_o(reg_write_o), .mem_write_o(mem_write_o),
    .pc_src_o(pc_src_o), .rd_o(rd_o), .cond_ex_o(cond_ex_o), .flags_o(flags_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference condition table, decoded ARM-style: base test on cond[3:1],
  // inverted by cond[0], except the 111x group which always passes.
  function automatic logic cond_ref(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (cond[3:1] == 3'd7) return 1'b1;
    return cond[0] ? !base : base;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: one op, waits (bounded) for in_ready_o, updates the flag model
  task automatic send(input logic [N-1:0] res, input logic [3:0] af, input logic [3:0] cond,
                      input logic [1:0] fw, input logic rw, input logic mw, input logic pc,
                      input logic [REG_AW-1:0] rd);
    int guard;
    logic cex;
    guard = 0;
    while (!in_ready_o && guard < 50) begin
      @(posedge clk_i); #1;
      guard++;
    end
    if (!in_ready_o) begin
      n_vec++; n_err++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end else begin
      in_valid_i = 1'b1; result_i = res; alu_flags_i = af; cond_i = cond;
      flag_w_i = fw; reg_write_i = rw; mem_write_i = mw; pc_src_i = pc; rd_i = rd;
      cex = cond_ref(cond, tb_flags);
      exp_q.push_back({res, rd, cex, rw & cex, mw & cex, pc & cex});
      if (cex && fw[1]) tb_flags[3:2] = af[3:2];
      if (cex && fw[0]) tb_flags[1:0] = af[1:0];
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(posedge clk_i); #1;
      guard++;
    end
    check("drain_empty", W'(exp_q.size()), '0);
  endtask

  // monitor: a pop happens at the next rising edge
  always @(negedge clk_i) begin
    if (rst_ni && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_pop: got %h expected none",
                 {result_o, rd_o, cond_ex_o, reg_write_o, mem_write_o, pc_src_o});
      end else begin
        check("head_entry", {result_o, rd_o, cond_ex_o, reg_write_o, mem_write_o, pc_src_o},
              exp_q.pop_front());
      end
    end
  end

  initial begin
    n_vec = 0; n_err = 0; tb_flags = 4'b0000;
    in_valid_i = 0; result_i = 0; alu_flags_i = 0; cond_i = 0; flag_w_i = 0;
    reg_write_i = 0; mem_write_i = 0; pc_src_i = 0; rd_i = 0; out_ready_i = 1'b1;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_out_valid", W'(out_valid_o), W'(0));
    check("reset_in_ready", W'(in_ready_o), W'(1));
    check("reset_flags", W'(flags_o), W'(0));
    check("reset_head", {result_o, rd_o, cond_ex_o, reg_write_o, mem_write_o, pc_src_o}, '0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // SUBS-like op then EQ
    send(4'h0, 4'b0110, 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 4'h1);
    check("subs_flags", W'(flags_o), W'(4'b0110));
    send(4'h5, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 4'h2);
    drain();

    // failed cond: flags 0000, EQ fails, mem_write gated, flags unchanged
    send(4'h0, 4'b0000, 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 4'h0);
    send(4'h9, 4'b1111, 4'b0000, 2'b11, 1'b0, 1'b1, 1'b1, 4'h3);
    check("failed_cond_flags", W'(flags_o), W'(4'b0000));
    drain();

    // partial update of C,V only
    send(4'h0, 4'b1111, 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 4'h0);
    send(4'h1, 4'b0000, 4'b1110, 2'b01, 1'b1, 1'b1, 1'b1, 4'h4);
    check("partial_flags", W'(flags_o), W'(4'b1100));
    drain();

    // backpressure: 3 ops with writeback stalled, release later
    out_ready_i = 1'b0;
    send(4'h1, 4'b0000, 4'b1110, 2'b00, 1'b1, 1'b0, 1'b0, 4'h5);
    check("one_entry_ready", W'(in_ready_o), W'(1));
    send(4'h2, 4'b0000, 4'b1110, 2'b00, 1'b1, 1'b0, 1'b0, 4'h6);
    check("full_ready", W'(in_ready_o), W'(0));
    check("full_head_result", W'(result_o), W'(4'h1));
    fork
      send(4'h3, 4'b0000, 4'b1110, 2'b00, 1'b1, 1'b0, 1'b0, 4'h7);
      begin
        repeat (3) @(posedge clk_i);
        #2;
        check("stall_head_held", W'(result_o), W'(4'h1));
        out_ready_i = 1'b1;
      end
    join
    drain();
    check("bp_out_valid_idle", W'(out_valid_o), W'(0));

    // sweep every cond against every flag value
    for (int f = 0; f < 16; f++) begin
      send(4'(f), 4'(f), 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 4'h0);
      check("sweep_flags", W'(flags_o), W'(f));
      for (int c = 0; c < 16; c++)
        send(4'(c), 4'b0000, 4'(c), 2'b00, 1'b1, 1'b1, 1'b1, 4'(f));
    end
    drain();

    // mid-stream async reset with two entries buffered
    out_ready_i = 1'b0;
    send(4'hA, 4'b1010, 4'b1110, 2'b11, 1'b1, 1'b0, 1'b0, 4'h1);
    send(4'hB, 4'b0000, 4'b1110, 2'b00, 1'b1, 1'b0, 1'b0, 4'h2);
    check("pre_reset_valid", W'(out_valid_o), W'(1));
    #2;
    rst_ni = 1'b0;
    #1;
    check("midreset_out_valid", W'(out_valid_o), W'(0));
    check("midreset_flags", W'(flags_o), W'(0));
    check("midreset_in_ready", W'(in_ready_o), W'(1));
    exp_q.delete();
    tb_flags = 4'b0000;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("post_reset_no_replay", W'(out_valid_o), W'(0));
    send(4'hC, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 4'h3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
